// File: rtl/seq_divider_32_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package seq_divider_32_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 6;
  localparam int unsigned DIV_ITER  = DEF_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_32_div_step.sv
// One restoring-division iteration: shift {P,Q}, trial-subtract D, restore on borrow.
module seq_divider_32_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {p[WIDTH-1:0], q[WIDTH-1]};
  // Subtract as an add of the inverted divisor with carry-in 1.
  assign trial   = shifted + ~{1'b0, d} + (WIDTH+1)'(1);

  always_comb begin
    if (!trial[WIDTH]) begin
      p_next = trial;
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      p_next = shifted;
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle DIV/DIVU unit: fixed WIDTH+2 cycle latency, sign fix-up after magnitude division.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  state_t state, state_n;

  logic [WIDTH:0]   p, p_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_raw;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic             accept;
  logic             last_iter;

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  seq_divider_32_div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .q      (q),
    .d      (dvs),
    .p_next (p_n),
    .q_next (q_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_RUN;
      S_RUN:  if (last_iter) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = start ? S_RUN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p         <= '0;
      q         <= '0;
      dvs       <= '0;
      dvd_raw   <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r    <= is_signed && dividend[WIDTH-1];
        q        <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs      <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
        dvd_raw  <= dividend;
        div_zero <= (divisor == '0);
        p        <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            p   <= p_n;
            q   <= q_n;
            cnt <= cnt + CNT_W'(1);
          end
          S_FIX: begin
            quotient  <= div_zero ? '1 : (neg_q ? -q : q);
            remainder <= div_zero ? dvd_raw
                                  : (neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
            busy      <= 1'b0;
            done      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/seq_divider_32.md
Name: seq_divider_32

Overview:
Multi-cycle iterative restoring divider: the inverse of the ripple adders. Each iteration is one trial subtraction, i.e. an add of the inverted divisor with carry-in 1.
Sits beside the ALU in the execute stage and serves DIV/DIVU. The pipeline stalls on busy and writes back quotient/remainder (LO/HI) on done.
Constant latency regardless of operands. This includes divide-by-zero.

Parameters:
WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  request a division; sampled only when the start accept conditions below hold
is_signed  in  1  1 = two's-complement DIV, 0 = DIVU; sampled with start
dividend  in  WIDTH  numerator; sampled with start
divisor  in  WIDTH  denominator; sampled with start
busy  out  1  high in RUN and FIX
done  out  1  one-cycle pulse; results are valid from this cycle on
div_zero  out  1  divisor was 0 for the current/last operation; valid with done
quotient  out  WIDTH  result quotient; held stable until the next accepted start
remainder  out  WIDTH  result remainder; held stable until the next accepted start

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, div_zero=0, quotient=0, remainder=0; counter=0.
- States: IDLE, RUN, FIX, DONE. Encoding is 2 bits.
- Start accept: start is accepted at a clock edge only while in IDLE or DONE.
- On accept: capture is_signed and the operand signs, |dividend| and |divisor| (magnitudes when is_signed=1, raw values otherwise), and div_zero=(divisor==0).
  Clear the WIDTH+1-bit partial remainder, counter=0, state goes to RUN.
- start is ignored in RUN and FIX; operand changes during RUN have no effect.
- RUN, one iteration per edge:
  - Shift {P,Q} left by 1, bringing the next dividend MSB into P.
  - T = P - |divisor|, computed WIDTH+1 bits wide as P + ~D + 1.
  - If T is non-negative: P=T and the quotient LSB is 1. Otherwise P is restored and the quotient LSB is 0.
  - After WIDTH iterations (counter==WIDTH-1 at the edge), go to FIX.
- FIX, one edge; goes to DONE:
  - div_zero=1: quotient=all ones, remainder=raw dividend.
  - Otherwise, signed: negate Q if the operand signs differ; negate R if the dividend is negative. Quotient truncates toward zero and the remainder takes the dividend's sign.
  - Unsigned: quotient=Q, remainder=P[WIDTH-1:0].
  - -2^(WIDTH-1) / -1 yields quotient=0x80000000, remainder=0 by natural wrap; there is no trap.
- DONE: done=1 for this single cycle.
  - Next edge: with start, accept (back-to-back operation, done drops); otherwise go to IDLE.
- Latency: the accepting edge is edge 0, and done is high in the cycle following edge WIDTH+1 (edge 33 for WIDTH=32).
- busy rises in the cycle after the accepting edge and falls when DONE is entered.
- Reset mid-operation aborts immediately; no partial results are visible. The next start behaves as from a cold reset.

Decomposition:
- Shared package: WIDTH default, state encodings (S_IDLE=0, S_RUN=1, S_FIX=2, S_DONE=3), DIV_ITER=WIDTH.
- One sub-module div_step (combinational): inputs partial remainder, quotient, divisor; outputs next partial remainder, next quotient.
  - Contains the shift, the WIDTH+1-bit subtract, and the restore mux, so it is unit-testable in isolation.
- Sign negations are done in the top level.

Test Plan:
- DIVU 100/7, start pulsed one cycle -> busy for 33 cycles, done in the cycle after edge 33; quotient=14, remainder=2, div_zero=0.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- DIVU 5/0 and DIV -5/0 -> div_zero=1, quotient=0xFFFFFFFF, remainder=dividend, same 33-cycle latency.
- Start held high in RUN with new operands -> ignored, first result unchanged.
  - Start in the DONE cycle -> the second operation is accepted and its done follows 33 edges later.
- Assert rst at iteration 10 -> busy, done, quotient and remainder are all 0 immediately (asynchronously).
  - After release, DIVU 9/3 -> quotient=3, remainder=0.
